// File: rtl/alu_pkg.sv
// Shared types for the ALU and its front-end operand sequencer.
package alu_pkg;

  // ALU operation select. Only codes 0..OP_MAX are legal.
  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    OR  = 3'd2,
    AND = 3'd3
  } opcode_t;

  localparam logic [2:0] OP_MAX = 3'd3;

  // ALU flags: negative, zero, carry, overflow.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } status_t;

  // Sequencer states. The encodings are exported on state_o for the LEDs.
  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/edge_detect.sv
// One-cycle pulse on each rising edge of a synchronous level input.
// The previous-level register resets to RESET_VAL. With RESET_VAL = 1, an
// input that is already high when reset is released produces no pulse.
module edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic pulse_o
);

  logic prev_q;
  logic prev_d;

  assign prev_d  = sig_i;
  assign pulse_o = sig_i & ~prev_q;

  // Remember the input level from the previous cycle.
  always_ff @(posedge clk) begin
    if (reset) prev_q <= RESET_VAL;
    else       prev_q <= prev_d;
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Front end for the combinational ALU. It collects operand A, operand B and
// the opcode from a shared switch bus, one per enter press. It lets the ALU
// evaluate for one cycle, then captures Result/Status and holds them for
// display until the next transaction starts.
//
// Handshake: there is no valid/ready pair. enter is a one-cycle pulse derived
// from the button. It is consumed only in the WAIT_* and DONE states and is
// ignored in EXEC. result_valid is a level: it is high from the EXEC capture
// until the next operand-A capture.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic         enter_btn,
  output logic [N-1:0] alu_A,
  output logic [N-1:0] alu_B,
  output opcode_t      alu_op,
  input  logic [N-1:0] alu_result,
  input  status_t      alu_status,
  output logic [N-1:0] result_q,
  output status_t      status_q,
  output logic         result_valid,
  output logic         op_error,
  output logic [2:0]   state_o
);

  logic enter;

  edge_detect #(.RESET_VAL(1'b1)) u_enter_edge (
    .clk     (clk),
    .reset   (reset),
    .sig_i   (enter_btn),
    .pulse_o (enter)
  );

  seq_state_t   state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  opcode_t      op_q, op_d;
  logic [N-1:0] res_q, res_d;
  status_t      stat_q, stat_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  // Next state and next register contents. Every register holds its value
  // unless the current state explicitly captures into it.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    stat_d  = stat_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      ST_WAIT_A: begin
        if (enter) begin
          a_d     = data_in;
          valid_d = 1'b0;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (enter) begin
          b_d     = data_in;
          state_d = ST_WAIT_OP;
        end
      end
      ST_WAIT_OP: begin
        if (enter) begin
          if (data_in[2:0] <= OP_MAX) begin
            op_d    = opcode_t'(data_in[2:0]);
            err_d   = 1'b0;
            state_d = ST_EXEC;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        // The ALU inputs have been stable since the opcode edge, so the
        // result is settled here. Any enter pulse in this cycle is dropped.
        res_d   = alu_result;
        stat_d  = alu_status;
        valid_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (enter) state_d = ST_WAIT_A;
      end
      default: state_d = ST_WAIT_A;
    endcase
  end

  // State and datapath registers. Reset takes priority over every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ADD;
      res_q   <= '0;
      stat_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      stat_q  <= stat_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign alu_A        = a_q;
  assign alu_B        = b_q;
  assign alu_op       = op_q;
  assign result_q     = res_q;
  assign status_q     = stat_q;
  assign result_valid = valid_q;
  assign op_error     = err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer. A behavioural ALU drives the result and
// status inputs. The expected results are computed from the operands the
// bench itself entered.
module tb_alu_operand_sequencer;
  import alu_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] data_in = '0;
  logic         enter_btn = 1'b0;
  logic [N-1:0] alu_A, alu_B, alu_result, result_q;
  opcode_t      alu_op;
  status_t      alu_status, status_q;
  logic         result_valid, op_error;
  logic [2:0]   state_o;

  int checks = 0;
  int failures = 0;

  alu_operand_sequencer #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .enter_btn    (enter_btn),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_status   (alu_status),
    .result_q     (result_q),
    .status_q     (status_q),
    .result_valid (result_valid),
    .op_error     (op_error),
    .state_o      (state_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Reference ALU: returns {result, n, z, c, v}.
  function automatic logic [N+3:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [2:0] op);
    logic [N:0]   wide;
    logic [N-1:0] r;
    logic         c, v;
    c = 1'b0; v = 1'b0; r = '0; wide = '0;
    case (op)
      3'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[N-1:0]; c = wide[N];
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      3'd1: begin
        r = a - b; c = (a >= b);
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      3'd2: r = a | b;
      3'd3: r = a & b;
      default: r = '0;
    endcase
    return {r, r[N-1], (r == '0), c, v};
  endfunction

  always_comb {alu_result, alu_status} = alu_fn(alu_A, alu_B, alu_op);

  // driver tasks
  task automatic press(input logic [N-1:0] d);
    @(negedge clk); data_in = d; enter_btn = 1'b1;
    @(negedge clk); enter_btn = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; enter_btn = 1'b0;
    @(negedge clk); @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    checks++; if ({alu_A, alu_B, alu_op} !== {8'h00, 8'h00, ADD}) begin failures++;
      $display("FAIL reset_alu_in got=%h/%h/%0d exp=0/0/0", alu_A, alu_B, alu_op); end
    checks++; if ({result_q, status_q, result_valid, op_error} !== 14'd0) begin failures++;
      $display("FAIL reset_outputs got=%h/%b/%b/%b exp=0", result_q, status_q, result_valid, op_error); end
  endtask

  task automatic test_add_latency();
    press(8'h7F); press(8'h01); press(8'h00);
    checks++; if ({state_o, result_valid} !== {3'd3, 1'b0}) begin failures++;
      $display("FAIL add_edge1 state=%0d valid=%b exp 3/0", state_o, result_valid); end
    @(negedge clk);
    checks++; if ({state_o, result_valid} !== {3'd4, 1'b1}) begin failures++;
      $display("FAIL add_edge2 state=%0d valid=%b exp 4/1", state_o, result_valid); end
    checks++; if (result_q !== 8'h80) begin failures++; $display("FAIL add_result got=%h exp=80", result_q); end
    checks++; if (status_q !== 4'b1001) begin failures++; $display("FAIL add_status got=%b exp=1001", status_q); end
  endtask

  task automatic test_sub_zero();
    press(8'h00); // leave DONE
    press(8'h05); press(8'h05); press(8'h01); @(negedge clk);
    checks++; if ({result_q, status_q.z, result_valid} !== {8'h00, 1'b1, 1'b1}) begin failures++;
      $display("FAIL sub_zero got=%h z=%b valid=%b exp 00/1/1", result_q, status_q.z, result_valid); end
    press(8'h00);
    checks++; if ({state_o, result_valid} !== {3'd0, 1'b1}) begin failures++;
      $display("FAIL done_exit state=%0d valid=%b exp 0/1", state_o, result_valid); end
    press(8'h3C);
    checks++; if ({state_o, result_valid} !== {3'd1, 1'b0}) begin failures++;
      $display("FAIL a_capture_clears state=%0d valid=%b exp 1/0", state_o, result_valid); end
  endtask

  task automatic test_op_error();
    // WAIT_B now, A = 0x3C already entered
    press(8'h0F);
    press(8'h06);
    checks++; if ({op_error, state_o, alu_op} !== {1'b1, 3'd2, SUB}) begin failures++;
      $display("FAIL op_illegal err=%b state=%0d op=%0d exp 1/2/1", op_error, state_o, alu_op); end
    press(8'h03);
    checks++; if ({op_error, state_o} !== {1'b0, 3'd3}) begin failures++;
      $display("FAIL op_legal err=%b state=%0d exp 0/3", op_error, state_o); end
    @(negedge clk);
    checks++; if ({state_o, result_q} !== {3'd4, 8'h0C}) begin failures++;
      $display("FAIL op_and state=%0d res=%h exp 4/0c", state_o, result_q); end
    press(8'h00);
  endtask

  task automatic test_hold_button();
    logic [N-1:0] first;
    @(negedge clk); first = 8'(($urandom_range(0, 255))); data_in = first; enter_btn = 1'b1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk); data_in = 8'($urandom_range(0, 255));
    end
    @(negedge clk); enter_btn = 1'b0;
    checks++; if ({state_o, alu_A} !== {3'd1, first}) begin failures++;
      $display("FAIL hold_one_pulse state=%0d A=%h exp 1/%h", state_o, alu_A, first); end
    @(negedge clk); reset = 1'b1; enter_btn = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    repeat (5) @(negedge clk);
    enter_btn = 1'b0;
    checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL hold_through_reset state=%0d exp 0", state_o); end
  endtask

  task automatic test_reset_in_exec();
    press(8'hF0); press(8'h0F); press(8'h02);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks++; if ({state_o, result_q, status_q, result_valid, alu_op} !== {3'd0, 8'h00, 4'h0, 1'b0, ADD}) begin
      failures++;
      $display("FAIL reset_exec state=%0d res=%h st=%b valid=%b op=%0d exp 0/00/0000/0/0",
               state_o, result_q, status_q, result_valid, alu_op); end
  endtask

  task automatic test_exec_stable();
    logic [N-1:0] a, b;
    a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
    press(a); press(b);
    // Opcode press with the button held through EXEC and DONE while the bus churns.
    @(negedge clk); data_in = 8'h01; enter_btn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); data_in = 8'($urandom_range(0, 255));
    end
    checks++; if ({alu_A, alu_B, alu_op, state_o} !== {a, b, SUB, 3'd4}) begin failures++;
      $display("FAIL exec_stable A=%h B=%h op=%0d state=%0d exp %h/%h/1/4", alu_A, alu_B, alu_op, state_o, a, b); end
    checks++; if (result_q !== 8'(a - b)) begin failures++;
      $display("FAIL exec_result got=%h exp=%h", result_q, 8'(a - b)); end
    @(negedge clk); enter_btn = 1'b0;
    press(8'h00);
  endtask

  // scoreboard: expected queue filled at operand entry, drained at completion
  logic [N+3:0] exp_q[$];

  task automatic test_random();
    logic [N-1:0] a, b, got;
    logic [2:0]   op;
    logic [N+3:0] e;
    for (int t = 0; t < 10; t++) begin
      a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
      op = 3'($urandom_range(0, 7));
      press(a); press(b);
      if (op > 3'd3) begin
        press({5'($urandom_range(0, 31)), op});
        checks++; if ({op_error, state_o} !== {1'b1, 3'd2}) begin failures++;
          $display("FAIL rnd_illegal t=%0d err=%b state=%0d exp 1/2", t, op_error, state_o); end
        op = op - 3'd4;
      end
      exp_q.push_back(alu_fn(a, b, op));
      press({5'($urandom_range(0, 31)), op});
      @(negedge clk);
      e = exp_q.pop_front();
      got = result_q;
      checks++; if ({got, status_q, result_valid, op_error} !== {e, 1'b1, 1'b0}) begin failures++;
        $display("FAIL rnd_txn t=%0d a=%h b=%h op=%0d got=%h/%b/%b/%b exp=%h/%b/1/0",
                 t, a, b, op, got, status_q, result_valid, op_error, e[N+3:4], e[3:0]); end
      press(8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_sub_zero();
    test_op_error();
    test_hold_button();
    test_reset_in_exec();
    test_exec_stable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Front-end initiator that drives the team's combinational N-bit ALU (opcode_t/status_t interface) from a single shared data switch bus and one "enter" button.
- Sequentially captures operand A, operand B and the opcode.
- Presents them to the ALU, registers the ALU's Result and Status one cycle later, and holds them for display until the next transaction.
- Sits between the board I/O (switches, button, LEDs/7-seg driver) and the ALU.

Parameters:
N, 8, operand/result width in bits

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
data_in  input  N  switch bus; sampled as A, B or opcode (bits [2:0]) depending on state
enter_btn  input  1  raw level of "enter" button (already debounced, synchronous to clk)
alu_A  output  N  operand A to ALU (registered)
alu_B  output  N  operand B to ALU (registered)
alu_op  output  opcode_t  opcode to ALU (registered)
alu_result  input  N  Result from ALU (combinational)
alu_status  input  status_t  Status {N,Z,C,V} from ALU
result_q  output  N  captured result
status_q  output  status_t  captured status
result_valid  output  1  high while result_q/status_q hold a completed transaction
op_error  output  1  high after an illegal opcode entry, until next enter pulse
state_o  output  3  current FSM state encoding, for LEDs

Behaviour:
- One clock, clk. Reset is synchronous and active-high. All state is updated on the rising edge of clk.
- Edge detect: enter = enter_btn & ~enter_prev.
  - enter_prev resets to 1, so a button held through reset produces no pulse.
  - Holding the button high yields exactly one enter pulse.
- Reset values:
  - state = WAIT_A
  - alu_A = 0, alu_B = 0, alu_op = ADD
  - result_q = 0, status_q = 0
  - result_valid = 0, op_error = 0
- FSM states and state_o codes: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, DONE=4.
  - WAIT_A: on enter, alu_A <= data_in, result_valid <= 0, go to WAIT_B.
  - WAIT_B: on enter, alu_B <= data_in, go to WAIT_OP.
  - WAIT_OP: on enter with data_in[2:0] <= 3:
    - alu_op <= data_in[2:0], op_error <= 0, go to EXEC.
  - WAIT_OP: on enter with data_in[2:0] in 4..7:
    - alu_op unchanged, op_error <= 1, stay in WAIT_OP.
  - EXEC: unconditional single cycle.
    - result_q <= alu_result, status_q <= alu_status, result_valid <= 1, go to DONE.
    - An enter pulse arriving during EXEC is ignored.
  - DONE: hold all outputs. On enter, go to WAIT_A; result_valid stays 1 until the WAIT_A capture.
- Latency: result_valid rises 2 clk edges after the opcode-accepting enter edge.
  - Edge 1: opcode registered.
  - Edge 2: result captured.
- alu_A, alu_B and alu_op change only on their own capture edge, so the ALU inputs are stable throughout EXEC.
- Widths: data_in[N-1:0] is stored unmodified. Only data_in[2:0] is used for the opcode; upper bits are ignored.
- No arithmetic is performed here. result_q and status_q are exact copies of the ALU outputs sampled in EXEC.
- Reset asserted in any state, including EXEC, overrides all transitions. All outputs return to reset values on that edge.
- Illegal state encodings (5..7) transition to WAIT_A on the next edge.

Decomposition:
- Shared package alu_pkg holds:
  - opcode_t (3-bit enum ADD=0, SUB=1, OR=2, AND=3)
  - status_t (packed {N,Z,C,V})
  - the state enum seq_state_t
  - the constant OP_MAX = 3
- The ALU and this block both import alu_pkg.
- Sub-module: edge_detect (1-bit rising-edge pulse generator, reset value parameter = 1), instantiated on enter_btn.
- The ALU itself is instantiated beside this block at top level, not inside it.

Test Plan:
1. Reset, then A=0x7F, B=0x01, op=0 (ADD) via three enter presses -> alu_result=0x80 captured. result_q=0x80, status_q N=1 V=1 Z=0, result_valid=1 exactly 2 cycles after the third enter edge, state_o=4.
2. A=0x05, B=0x05, op=1 (SUB) -> result_q=0x00, status_q.Z=1, result_valid=1. Next enter -> state_o=0 with result_valid still 1. Next enter (A capture) -> result_valid=0.
3. In WAIT_OP, enter with data_in=0x06 -> op_error=1, state_o=2, alu_op unchanged. Then enter with data_in=0x03 -> op_error=0, state_o=3 then 4, result_q=A&B.
4. Hold enter_btn high for 20 cycles in WAIT_A -> exactly one advance to WAIT_B. Hold enter_btn high through reset release -> no advance (state_o stays 0).
5. Assert reset during EXEC (A=0xF0, B=0x0F, OR) -> next edge: state_o=0, result_q=0, status_q=0, result_valid=0, alu_op=ADD. No capture of 0xFF.
6. Change data_in every cycle during EXEC and DONE, with an enter pulse in EXEC -> alu_A/alu_B/alu_op and result_q unchanged; the enter in EXEC is ignored and the state still reaches DONE.
